// File: rtl/sys_cmd_pkg.sv
// Shared types for the UART command controller:
// FSM states, command bytes and error response codes.
package sys_cmd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_ADDR,
    WR_LEN,
    WR_DATA,
    RD_ADDR,
    RD_LEN,
    RD_REQ,
    RD_WAIT,
    RD_SEND,
    ALU_OPA,
    ALU_OPB,
    ALU_FUN,
    ALU_WAIT,
    ALU_SEND_LO,
    ALU_SEND_HI,
    ERR_SEND
  } state_t;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU     = 8'hCC;
  localparam logic [7:0] CMD_ALU_FUN = 8'hDD;
  localparam logic [7:0] CMD_BWR     = 8'hA5;
  localparam logic [7:0] CMD_BRD     = 8'h5A;

  localparam logic [7:0] ERR_CMD = 8'hE1;
  localparam logic [7:0] ERR_LEN = 8'hE2;
  localparam logic [7:0] ERR_TMO = 8'hE3;

endpackage

// File: rtl/sys_cmd_timeout.sv
// Wait-state watchdog: loads CYC-1 on entry to a wait state,
// counts down while enabled and flags the last allowed cycle.
module sys_cmd_timeout #(
  parameter int CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(CYC + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(CYC - 1);
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = en && (cnt == '0);

endmodule

// File: rtl/sys_cmd_frame_ctrl.sv
// Framed UART command controller: RF single/burst access,
// ALU start and result return over a valid/ready TX port.
module sys_cmd_frame_ctrl
  import sys_cmd_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 4,
  parameter int FUN_W       = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   rx_data,
  input  logic                rx_valid,
  input  logic [DATA_W-1:0]   rf_rd_data,
  input  logic                rf_rd_valid,
  input  logic [2*DATA_W-1:0] alu_data,
  input  logic                alu_valid,
  input  logic                tx_ready,
  output logic                alu_en,
  output logic [FUN_W-1:0]    alu_fun,
  output logic                clk_gate_en,
  output logic                clk_div_en,
  output logic                rf_wr_en,
  output logic                rf_rd_en,
  output logic [ADDR_W-1:0]   rf_addr,
  output logic [DATA_W-1:0]   rf_wr_data,
  output logic                tx_valid,
  output logic [DATA_W-1:0]   tx_data,
  output logic                err_pulse,
  output logic                busy
);

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   cnt;
  logic [DATA_W-1:0]   hi_byte;
  logic                burst;
  logic                tmo_load;
  logic                tmo_en;
  logic                tmo_hit;
  logic                last;

  assign last = (cnt == DATA_W'(1));

  assign tmo_load = (state == RD_REQ) ||
                    (state == ALU_FUN && rx_valid);
  assign tmo_en   = (state == RD_WAIT) || (state == ALU_WAIT);

  sys_cmd_timeout #(
    .CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .load   (tmo_load),
    .en     (tmo_en),
    .expired(tmo_hit)
  );

  // Write strobes follow the data byte in the same cycle.
  assign rf_wr_en = rx_valid &&
                    (state == WR_DATA ||
                     state == ALU_OPA ||
                     state == ALU_OPB);
  assign rf_wr_data = rf_wr_en ? rx_data : '0;
  assign rf_rd_en   = (state == RD_REQ);
  assign rf_addr    = (state == ALU_OPA) ? ADDR_W'(0) :
                      (state == ALU_OPB) ? ADDR_W'(1) : addr;

  assign alu_en  = rx_valid && (state == ALU_FUN);
  assign alu_fun = alu_en ? rx_data[FUN_W-1:0] : '0;

  assign clk_gate_en = (state == ALU_FUN)     ||
                       (state == ALU_WAIT)    ||
                       (state == ALU_SEND_LO) ||
                       (state == ALU_SEND_HI);
  assign clk_div_en  = 1'b1;

  assign tx_valid = (state == RD_SEND)     ||
                    (state == ALU_SEND_LO) ||
                    (state == ALU_SEND_HI) ||
                    (state == ERR_SEND);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      cnt       <= '0;
      hi_byte   <= '0;
      burst     <= 1'b0;
      tx_data   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: if (rx_valid) begin
          case (rx_data)
            DATA_W'(CMD_WR): begin
              burst <= 1'b0;
              state <= WR_ADDR;
            end
            DATA_W'(CMD_BWR): begin
              burst <= 1'b1;
              state <= WR_ADDR;
            end
            DATA_W'(CMD_RD): begin
              burst <= 1'b0;
              state <= RD_ADDR;
            end
            DATA_W'(CMD_BRD): begin
              burst <= 1'b1;
              state <= RD_ADDR;
            end
            DATA_W'(CMD_ALU):     state <= ALU_OPA;
            DATA_W'(CMD_ALU_FUN): state <= ALU_FUN;
            default: begin
              tx_data   <= DATA_W'(ERR_CMD);
              err_pulse <= 1'b1;
              state     <= ERR_SEND;
            end
          endcase
        end
        WR_ADDR: if (rx_valid) begin
          addr <= rx_data[ADDR_W-1:0];
          if (burst) begin
            state <= WR_LEN;
          end else begin
            cnt   <= DATA_W'(1);
            state <= WR_DATA;
          end
        end
        WR_LEN: if (rx_valid) begin
          if (rx_data == '0) begin
            tx_data   <= DATA_W'(ERR_LEN);
            err_pulse <= 1'b1;
            state     <= ERR_SEND;
          end else begin
            cnt   <= rx_data;
            state <= WR_DATA;
          end
        end
        WR_DATA: if (rx_valid) begin
          addr <= addr + ADDR_W'(1);
          cnt  <= cnt - DATA_W'(1);
          if (last) state <= IDLE;
        end
        RD_ADDR: if (rx_valid) begin
          addr <= rx_data[ADDR_W-1:0];
          if (burst) begin
            state <= RD_LEN;
          end else begin
            cnt   <= DATA_W'(1);
            state <= RD_REQ;
          end
        end
        RD_LEN: if (rx_valid) begin
          if (rx_data == '0) begin
            tx_data   <= DATA_W'(ERR_LEN);
            err_pulse <= 1'b1;
            state     <= ERR_SEND;
          end else begin
            cnt   <= rx_data;
            state <= RD_REQ;
          end
        end
        RD_REQ: state <= RD_WAIT;
        // Data arriving on the expiry cycle beats the timeout.
        RD_WAIT: begin
          if (rf_rd_valid) begin
            tx_data <= rf_rd_data;
            state   <= RD_SEND;
          end else if (tmo_hit) begin
            tx_data   <= DATA_W'(ERR_TMO);
            err_pulse <= 1'b1;
            state     <= ERR_SEND;
          end
        end
        RD_SEND: if (tx_ready) begin
          addr  <= addr + ADDR_W'(1);
          cnt   <= cnt - DATA_W'(1);
          state <= last ? IDLE : RD_REQ;
        end
        ALU_OPA: if (rx_valid) state <= ALU_OPB;
        ALU_OPB: if (rx_valid) state <= ALU_FUN;
        ALU_FUN: if (rx_valid) state <= ALU_WAIT;
        ALU_WAIT: begin
          if (alu_valid) begin
            tx_data <= alu_data[DATA_W-1:0];
            hi_byte <= alu_data[2*DATA_W-1:DATA_W];
            state   <= ALU_SEND_LO;
          end else if (tmo_hit) begin
            tx_data   <= DATA_W'(ERR_TMO);
            err_pulse <= 1'b1;
            state     <= ERR_SEND;
          end
        end
        ALU_SEND_LO: if (tx_ready) begin
          tx_data <= hi_byte;
          state   <= ALU_SEND_HI;
        end
        ALU_SEND_HI: if (tx_ready) state <= IDLE;
        ERR_SEND:    if (tx_ready) state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_cmd_frame_ctrl.sv
// Randomised frame bench with a frame-level reference model
// of RF writes, TX bytes, errors and ALU starts.
module tb_sys_cmd_frame_ctrl;

  localparam int T = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  rf_rd_data;
  logic        rf_rd_valid;
  logic [15:0] alu_data;
  logic        alu_valid;
  logic        tx_ready;
  logic        alu_en;
  logic [3:0]  alu_fun;
  logic        clk_gate_en;
  logic        clk_div_en;
  logic        rf_wr_en;
  logic        rf_rd_en;
  logic [3:0]  rf_addr;
  logic [7:0]  rf_wr_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        err_pulse;
  logic        busy;

  sys_cmd_frame_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rf_rd_data (rf_rd_data),
    .rf_rd_valid(rf_rd_valid),
    .alu_data   (alu_data),
    .alu_valid  (alu_valid),
    .tx_ready   (tx_ready),
    .alu_en     (alu_en),
    .alu_fun    (alu_fun),
    .clk_gate_en(clk_gate_en),
    .clk_div_en (clk_div_en),
    .rf_wr_en   (rf_wr_en),
    .rf_rd_en   (rf_rd_en),
    .rf_addr    (rf_addr),
    .rf_wr_data (rf_wr_data),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .err_pulse  (err_pulse),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // environment RF contents and reference-model RF
  logic [7:0]  rf_mem [16];
  logic [7:0]  ref_rf [16];
  logic [7:0]  frm [$];
  logic [11:0] act_wr [$];
  logic [11:0] exp_wr [$];
  logic [7:0]  act_tx [$];
  logic [7:0]  exp_tx [$];
  int act_err, act_alu, act_rd;
  int exp_err, exp_alu, exp_rd;
  logic [3:0]  act_fun, exp_fun;
  logic [15:0] alu_val;
  int cyc = 0;
  int last_rd_cyc, err_cyc;
  bit rd_pend, rd_resp, alu_pend;
  int rd_dly, alu_dly, hold_left;
  logic [3:0] rd_a;
  bit hold_chk;
  logic [7:0] hold_d;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!reset) begin
    if (hold_chk) begin
      chk("tx_hold_valid", tx_valid, 1);
      chk("tx_hold_data", tx_data, hold_d);
    end
    if (rf_wr_en) begin
      act_wr.push_back({rf_addr, rf_wr_data});
      rf_mem[rf_addr] = rf_wr_data;
    end
    if (rf_rd_en) begin
      act_rd++;
      rd_pend = 1;
      rd_a = rf_addr;
      rd_dly = $urandom_range(0, 3);
      last_rd_cyc = cyc;
    end
    if (alu_en) begin
      act_alu++;
      act_fun = alu_fun;
      alu_pend = 1;
      alu_dly = $urandom_range(0, 4);
      chk("gate_on_alu_en", clk_gate_en, 1);
    end
    if (err_pulse) begin
      act_err++;
      err_cyc = cyc;
    end
    if (tx_valid && tx_ready) act_tx.push_back(tx_data);
    hold_chk = tx_valid && !tx_ready;
    hold_d = tx_data;
  end

  initial forever begin
    @(posedge clk);
    #2;
    rf_rd_valid = 0;
    alu_valid = 0;
    if (rd_pend && rd_resp) begin
      if (rd_dly == 0) begin
        rf_rd_valid = 1;
        rf_rd_data = rf_mem[rd_a];
        rd_pend = 0;
      end else rd_dly--;
    end
    if (alu_pend) begin
      if (alu_dly == 0) begin
        alu_valid = 1;
        alu_data = alu_val;
        alu_pend = 0;
      end else alu_dly--;
    end
    if (hold_left > 0) begin
      tx_ready = 0;
      if (tx_valid) hold_left--;
    end else begin
      tx_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Frame-level expectation derived from the command rules.
  task automatic model(input bit to_mode);
    int a, len;
    exp_wr.delete();
    exp_tx.delete();
    exp_err = 0;
    exp_alu = 0;
    exp_rd = 0;
    exp_fun = 0;
    case (frm[0])
      8'hAA: begin
        a = frm[1] % 16;
        exp_wr.push_back({4'(a), frm[2]});
        ref_rf[a] = frm[2];
      end
      8'hA5: begin
        len = frm[2];
        if (len == 0) begin
          exp_tx.push_back(8'hE2);
          exp_err = 1;
        end else begin
          for (int i = 0; i < len; i++) begin
            a = (frm[1] + i) % 16;
            exp_wr.push_back({4'(a), frm[3+i]});
            ref_rf[a] = frm[3+i];
          end
        end
      end
      8'hBB: begin
        exp_rd = 1;
        if (to_mode) begin
          exp_tx.push_back(8'hE3);
          exp_err = 1;
        end else exp_tx.push_back(ref_rf[frm[1] % 16]);
      end
      8'h5A: begin
        len = frm[2];
        if (len == 0) begin
          exp_tx.push_back(8'hE2);
          exp_err = 1;
        end else begin
          exp_rd = len;
          for (int i = 0; i < len; i++)
            exp_tx.push_back(ref_rf[(frm[1] + i) % 16]);
        end
      end
      8'hCC, 8'hDD: begin
        if (frm[0] == 8'hCC) begin
          exp_wr.push_back({4'd0, frm[1]});
          exp_wr.push_back({4'd1, frm[2]});
          ref_rf[0] = frm[1];
          ref_rf[1] = frm[2];
        end
        exp_alu = 1;
        exp_fun = frm[frm.size()-1] % 16;
        exp_tx.push_back(alu_val % 256);
        exp_tx.push_back(alu_val / 256);
      end
      default: begin
        exp_tx.push_back(8'hE1);
        exp_err = 1;
      end
    endcase
  endtask

  task automatic run_frame(input int hold, input bit to_mode);
    int n;
    model(to_mode);
    act_wr.delete();
    act_tx.delete();
    act_err = 0;
    act_alu = 0;
    act_rd = 0;
    rd_pend = 0;
    alu_pend = 0;
    rd_resp = !to_mode;
    @(posedge clk);
    #2;
    hold_left = hold;
    foreach (frm[i]) begin
      rx_data = frm[i];
      rx_valid = 1;
      @(posedge clk);
      #2;
      rx_valid = 0;
      if (hold == 0)
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #2;
        end
    end
    n = 0;
    while ((busy || hold_left > 0) && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("frame_done", (n < 3000), 1);
    chk("idle_busy", busy, 0);
    chk("idle_gate", clk_gate_en, 0);
    chk("idle_txv", tx_valid, 0);
    chk("n_writes", act_wr.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size() && i < act_wr.size(); i++)
      chk("wr_addr_data", act_wr[i], exp_wr[i]);
    chk("n_tx", act_tx.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < act_tx.size(); i++)
      chk("tx_byte", act_tx[i], exp_tx[i]);
    chk("n_err", act_err, exp_err);
    chk("n_rd_en", act_rd, exp_rd);
    chk("n_alu_en", act_alu, exp_alu);
    if (exp_alu != 0) chk("alu_fun", act_fun, exp_fun);
    rd_resp = 1;
  endtask

  task automatic rnd_frame();
    int k, len;
    logic [7:0] c;
    frm.delete();
    alu_val = 16'($urandom);
    k = $urandom_range(0, 6);
    case (k)
      0: begin
        frm.push_back(8'hAA);
        frm.push_back(8'($urandom));
        frm.push_back(8'($urandom));
      end
      1, 3: begin
        len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 5);
        frm.push_back(k == 1 ? 8'hA5 : 8'h5A);
        frm.push_back(8'($urandom));
        frm.push_back(8'(len));
        if (k == 1)
          for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
      end
      2: begin
        frm.push_back(8'hBB);
        frm.push_back(8'($urandom));
      end
      4: begin
        frm.push_back(8'hCC);
        frm.push_back(8'($urandom));
        frm.push_back(8'($urandom));
        frm.push_back(8'($urandom));
      end
      5: begin
        frm.push_back(8'hDD);
        frm.push_back(8'($urandom));
      end
      default: begin
        do c = 8'($urandom);
        while (c inside {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hA5, 8'h5A});
        frm.push_back(c);
      end
    endcase
  endtask

  initial begin
    reset = 1;
    rx_data = 0;
    rx_valid = 0;
    rf_rd_data = 0;
    rf_rd_valid = 0;
    alu_data = 0;
    alu_valid = 0;
    tx_ready = 0;
    rd_pend = 0;
    rd_resp = 1;
    alu_pend = 0;
    hold_left = 0;
    hold_chk = 0;
    alu_val = 0;
    for (int i = 0; i < 16; i++) begin
      rf_mem[i] = 0;
      ref_rf[i] = 0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_div", clk_div_en, 1);
    chk("rst_addr", rf_addr, 0);
    @(posedge clk);
    #2;
    reset = 0;

    frm = {8'hAA, 8'h03, 8'h5C};
    run_frame(0, 0);
    frm = {8'hA5, 8'h0E, 8'h03, 8'h11, 8'h22, 8'h33};
    run_frame(0, 0);
    frm = {8'hAA, 8'h02, 8'h07};
    run_frame(0, 0);
    frm = {8'hAA, 8'h03, 8'h09};
    run_frame(0, 0);
    frm = {8'h5A, 8'h02, 8'h02};
    run_frame(5, 0);
    alu_val = 16'h0130;
    frm = {8'hCC, 8'h10, 8'h20, 8'h00};
    run_frame(0, 0);
    frm = {8'hBB, 8'h04};
    run_frame(0, 1);
    chk("tmo_latency_ok",
        (err_cyc - last_rd_cyc >= T) &&
        (err_cyc - last_rd_cyc <= T + 2), 1);
    frm = {8'h77};
    run_frame(0, 0);
    frm = {8'hA5, 8'h00, 8'h00};
    run_frame(5, 0);

    // reset in the middle of a burst write
    act_wr.delete();
    @(posedge clk);
    #2;
    rx_valid = 1;
    rx_data = 8'hA5;
    @(posedge clk);
    #2;
    rx_data = 8'h05;
    @(posedge clk);
    #2;
    rx_data = 8'h03;
    @(posedge clk);
    #2;
    rx_data = 8'h66;
    @(posedge clk);
    #2;
    rx_valid = 0;
    chk("pre_rst_wr", (act_wr.size() == 1) ? act_wr[0] : 12'hFFF,
        {4'h5, 8'h66});
    ref_rf[5] = 8'h66;
    reset = 1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_txv", tx_valid, 0);
    chk("mid_rst_outs",
        {alu_en, clk_gate_en, rf_wr_en, rf_rd_en, err_pulse}, 0);
    chk("mid_rst_div", clk_div_en, 1);
    chk("mid_rst_addr_txd", {rf_addr, tx_data, rf_wr_data, alu_fun}, 0);
    @(posedge clk);
    #2;
    reset = 0;
    frm = {8'hAA, 8'h06, 8'hC3};
    run_frame(0, 0);

    for (int r = 0; r < 60; r++) begin
      rnd_frame();
      run_frame(0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
